// File: rtl/vlog_statmchs_sumn.sv
// vlog_statmchs_sumn
//   N-sample accumulator state machine. An accepted start latches the sample
//   count (clamped to N_MAX) and the arithmetic mode. The block then sums that
//   many d_valid-qualified unsigned samples and presents the result with a
//   one-cycle ready pulse. abort cancels a run. Saturating or wrapping
//   arithmetic can be selected. A sticky overflow flag records any carry out.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset
//   start    in   1      begin a run (sampled only in IDLE)
//   n        in   CW     sample count, latched on accepted start
//   sat_en   in   1      1 = saturate, 0 = wrap, latched on accepted start
//   abort    in   1      cancel the run in progress (ACC only)
//   d        in   DW     sample data
//   d_valid  in   1      d valid this cycle
//   sum      out  SUM_W  result, held until the next accepted start
//   ready    out  1      one-cycle pulse when sum/ovf are final
//   busy     out  1      high in ACC and DONE
//   ovf      out  1      carry out occurred in the current/last run
module vlog_statmchs_sumn #(
    parameter int DW    = 8,
    parameter int N_MAX = 16,
    parameter int SUM_W = 10,
    localparam int CW   = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    n,
    input  logic             sat_en,
    input  logic             abort,
    input  logic [DW-1:0]    d,
    input  logic             d_valid,
    output logic [SUM_W-1:0] sum,
    output logic             ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_n_l;
    logic             r_sat_l;
    logic [SUM_W-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [SUM_W-1:0] r_sum;
    logic             r_ready;
    logic             r_busy;
    logic             r_ovf;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_n_l_nxt;
    logic             w_sat_nxt;
    logic [SUM_W-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [SUM_W-1:0] w_sum_nxt;
    logic             w_ovf_nxt;

    logic [CW-1:0]    w_n_clamp;
    logic [SUM_W:0]   w_add;
    logic [SUM_W-1:0] w_acc_upd;
    logic [CW-1:0]    w_cnt_inc;

    assign w_n_clamp = (n > CW'(N_MAX)) ? CW'(N_MAX) : n;
    // One extra bit catches the carry out of the SUM_W-bit accumulator.
    assign w_add     = {1'b0, r_acc} + (SUM_W + 1)'(d);
    assign w_acc_upd = (w_add[SUM_W] && r_sat_l) ? '1 : w_add[SUM_W-1:0];
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_n_l_nxt   = r_n_l;
        w_sat_nxt   = r_sat_l;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_ovf_nxt   = r_ovf;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_n_l_nxt   = w_n_clamp;
                    w_sat_nxt   = sat_en;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (abort) begin
                    // A carry seen before the abort must not survive the cancelled run.
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (d_valid) begin
                    w_acc_nxt = w_acc_upd;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_add[SUM_W]) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (w_cnt_inc == r_n_l) begin
                        w_sum_nxt   = w_acc_upd;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_n_l   <= '0;
            r_sat_l <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n_l   <= w_n_l_nxt;
            r_sat_l <= w_sat_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
            // Flags are registered from the next state so they line up with it.
            r_ready <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign sum   = r_sum;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign ovf   = r_ovf;

endmodule
